// File: rtl/md_sched_if.sv
// Handshake bundle between the E-stage decode and the multiply/divide sequencer.
interface md_sched_if;
    logic [3:0]  md_op;
    logic        e_valid;
    logic        md_cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        busy;
    logic        start;
    logic        stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op, e_valid, md_cancel, rs_val, rt_val, d_uses_md,
        input  busy, start, stall, md_rdata, hi, lo
    );

    modport slave (
        input  md_op, e_valid, md_cancel, rs_val, rt_val, d_uses_md,
        output busy, start, stall, md_rdata, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div sequencer holding HI/LO; fixed-latency countdown, stall request to D.
// Optional madd/maddu/msub/msubu ops (9-12) are enabled by defining MD_MADD_EN.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk_i,
    input logic        reset_i,
    md_sched_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;

    logic busy, qualified, is_mult, is_div, start;

    assign busy      = (state_q == StBusy);
    assign qualified = bus.e_valid & ~bus.md_cancel & ~busy;

    always_comb begin
        is_mult = 1'b0;
        is_div  = 1'b0;
        case (bus.md_op)
            4'd1, 4'd2: is_mult = 1'b1;
            4'd3, 4'd4: is_div  = 1'b1;
`ifdef MD_MADD_EN
            4'd9, 4'd10, 4'd11, 4'd12: is_mult = 1'b1;
`endif
            default: ;
        endcase
    end

    assign start = qualified & (is_mult | is_div);

    // Result path works on latched operands and is only consumed at the completion edge.
    logic [63:0] prod_s, prod_u, hilo;
    logic [31:0] abs_a, abs_b, div_b, uq, ur, sq, sr, ud_q, ud_r;
    logic        div_zero;

    assign prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
    assign hilo     = {hi_q, lo_q};
    assign div_zero = (b_q == 32'd0);
    assign div_b    = div_zero ? 32'd1 : b_q;
    assign abs_a    = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b    = b_q[31] ? (32'd0 - b_q) : div_b;
    assign uq       = abs_a / abs_b;
    assign ur       = abs_a % abs_b;
    // Magnitude division avoids the signed-overflow corner; 0x80000000/-1 wraps to 0x80000000.
    assign sq       = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
    assign sr       = a_q[31] ? (32'd0 - ur) : ur;
    assign ud_q     = a_q / div_b;
    assign ud_r     = a_q % div_b;

    logic        res_we;
    logic [63:0] res;

    always_comb begin
        res_we = 1'b1;
        res    = hilo;
        case (op_q)
            4'd1: res = prod_s;
            4'd2: res = prod_u;
            4'd3: begin
                res    = {sr, sq};
                res_we = ~div_zero;
            end
            4'd4: begin
                res    = {ud_r, ud_q};
                res_we = ~div_zero;
            end
`ifdef MD_MADD_EN
            4'd9:  res = hilo + prod_s;
            4'd10: res = hilo + prod_u;
            4'd11: res = hilo - prod_s;
            4'd12: res = hilo - prod_u;
`endif
            default: res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StBusy;
                        op_q    <= bus.md_op;
                        a_q     <= bus.rs_val;
                        b_q     <= bus.rt_val;
                        cnt_q   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    end else if (qualified && bus.md_op == 4'd7) begin
                        hi_q <= bus.rs_val;
                    end else if (qualified && bus.md_op == 4'd8) begin
                        lo_q <= bus.rs_val;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StIdle;
                        if (res_we) begin
                            hi_q <= res[63:32];
                            lo_q <= res[31:0];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.start    = start;
    assign bus.stall    = bus.d_uses_md & (busy | start);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_rdata = (bus.md_op == 4'd5) ? hi_q :
                          (bus.md_op == 4'd6) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched; expected values are hand-computed constants.
module tb_md_sched;
    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    md_sched_if bus ();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic ev, input logic cancel,
                         input logic [31:0] rs, input logic [31:0] rt, input logic duse);
        bus.md_op     = op;
        bus.e_valid   = ev;
        bus.md_cancel = cancel;
        bus.rs_val    = rs;
        bus.rt_val    = rt;
        bus.d_uses_md = duse;
        #1;
    endtask

    task automatic idle();
        drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // mthi/mtlo must never reach E while the unit is busy.
    always @(negedge clk_i) begin
        if (!reset_i && bus.busy && bus.e_valid && (bus.md_op == 4'd7 || bus.md_op == 4'd8)) begin
            assert (1'b0) else begin
                errors++;
                $error("FAIL mt_while_busy observed=%h expected=0", bus.md_op);
            end
        end
    end

    initial begin
        idle();
        tick();
        tick();
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset_i = 1'b0;

        // Reset mid-operation discards the result.
        drive(4'd1, 1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
        chk("rmid_start", {31'd0, bus.start}, 32'd1);
        tick();
        idle();
        chk("rmid_busy1", {31'd0, bus.busy}, 32'd1);
        tick();
        reset_i = 1'b1;
        #1;
        chk("rmid_busy0", {31'd0, bus.busy}, 32'd0);
        chk("rmid_lo0", bus.lo, 32'd0);
        tick();
        reset_i = 1'b0;
        repeat (6) tick();
        chk("rmid_hi_late", bus.hi, 32'd0);
        chk("rmid_lo_late", bus.lo, 32'd0);

        // mult -1 x 2, exact latency.
        drive(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("mult_busy", {31'd0, bus.busy}, 32'd1);
            chk("mult_lo_pending", bus.lo, 32'd0);
            tick();
        end
        chk("mult_done", {31'd0, bus.busy}, 32'd0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFE);

        // multu same operands; cancel during busy must not abort.
        drive(4'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        tick();
        drive(4'd0, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
        repeat (5) tick();
        idle();
        chk("multu_busy", {31'd0, bus.busy}, 32'd0);
        chk("multu_hi", bus.hi, 32'd1);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        // div -7 / 2.
        drive(4'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick();
        idle();
        repeat (9) tick();
        chk("div_busy9", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("div_busy10", {31'd0, bus.busy}, 32'd0);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        // divu by zero: full latency, registers unchanged.
        drive(4'd4, 1'b1, 1'b0, 32'd7, 32'd0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            chk("divz_busy", {31'd0, bus.busy}, 32'd1);
            tick();
        end
        chk("divz_done", {31'd0, bus.busy}, 32'd0);
        chk("divz_hi", bus.hi, 32'hFFFF_FFFF);
        chk("divz_lo", bus.lo, 32'hFFFF_FFFD);

        // Signed overflow corner.
        drive(4'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        tick();
        idle();
        repeat (10) tick();
        chk("dovf_lo", bus.lo, 32'h8000_0000);
        chk("dovf_hi", bus.hi, 32'd0);

        // Stall window for mult with an md op waiting in D.
        drive(4'd1, 1'b1, 1'b0, 32'd6, 32'd7, 1'b1);
        chk("stall_start", {31'd0, bus.stall}, 32'd1);
        tick();
        drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_busy", {31'd0, bus.stall}, 32'd1);
            tick();
        end
        chk("stall_after", {31'd0, bus.stall}, 32'd0);
        drive(4'd6, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("mflo", bus.md_rdata, 32'd42);
        drive(4'd5, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("mfhi", bus.md_rdata, 32'd0);

        // Cancel in the issue cycle.
        drive(4'd3, 1'b1, 1'b1, 32'd10, 32'd3, 1'b0);
        chk("cancel_start", {31'd0, bus.start}, 32'd0);
        tick();
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        drive(4'd7, 1'b1, 1'b1, 32'h1234, 32'd0, 1'b0);
        tick();
        chk("mthi_cancel", bus.hi, 32'd0);
        drive(4'd7, 1'b1, 1'b0, 32'h1234, 32'd0, 1'b0);
        tick();
        chk("mthi", bus.hi, 32'h1234);

        // Accumulate setup: hi=0, lo=0xFFFFFFFF.
        drive(4'd8, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();
        drive(4'd7, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("acc_lo_init", bus.lo, 32'hFFFF_FFFF);
        chk("acc_hi_init", bus.hi, 32'd0);
        drive(4'd10, 1'b1, 1'b0, 32'd1, 32'd1, 1'b1);
`ifdef MD_MADD_EN
        chk("maddu_start", {31'd0, bus.start}, 32'd1);
        chk("maddu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        idle();
        repeat (5) tick();
        chk("maddu_hi", bus.hi, 32'd1);
        chk("maddu_lo", bus.lo, 32'd0);
`else
        chk("op10_start", {31'd0, bus.start}, 32'd0);
        chk("op10_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        idle();
        chk("op10_busy", {31'd0, bus.busy}, 32'd0);
        repeat (5) tick();
        chk("op10_hi", bus.hi, 32'd0);
        chk("op10_lo", bus.lo, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the multi-cycle multiply/divide resource in the E stage of the 5-stage MIPS pipeline.
- Accepts md operations from the E-stage decode and holds the HI/LO registers.
- Runs a busy countdown of fixed latency and commits results to HI/LO on completion.
- Raises a stall request so a D-stage md instruction cannot enter E while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–12 optional (see Optional Feature); others behave as none.
- e_valid  in  1  E-stage instruction valid (not a bubble).
- md_cancel  in  1  exception/interrupt in flight; suppresses start and mthi/mtlo this cycle.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- d_uses_md  in  1  D-stage instruction is any md op (1–12).
- busy  out  1  operation in flight.
- start  out  1  combinational; an operation is accepted this cycle.
- stall  out  1  combinational; freeze D and F, bubble into E.
- md_rdata  out  32  combinational; HI for op 5, LO for op 6, else 0.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
Reset and qualification:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, cnt=0, hi=0, lo=0, busy=0. Any in-flight result is discarded.
- Qualified op: e_valid & ~md_cancel & ~busy.
- start = qualified & md_op in {1,2,3,4} (plus 9–12 with the optional feature enabled).

State machine (two states):
- IDLE → BUSY on start.
  - Latch rs_val and rt_val into op registers and latch the op.
  - cnt := MULT_CYCLES or DIV_CYCLES.
- BUSY: cnt decrements every cycle. When cnt==1, HI/LO take the result at that edge; state → IDLE, busy → 0.
- busy is high for exactly N cycles after the start edge. A new start is possible in the first cycle busy is low.

mthi / mtlo:
- Only when qualified in IDLE: hi (or lo) := rs_val at the next edge.
- md_op 7/8 arriving while busy is an integration error; the D-stall prevents it and the bench asserts it never occurs.

Arithmetic (computed on latched operands, committed at completion):
- mult: signed 64-bit product; HI = upper 32 bits, LO = lower 32 bits.
- multu: unsigned 64-bit product, same HI/LO split.
- div: signed, quotient truncated toward zero; LO = quotient, HI = remainder (remainder takes the sign of the dividend).
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned; LO = quotient, HI = remainder.
- Divisor 0: full latency still runs; HI/LO unchanged at completion; no exception.

stall:
- stall = d_uses_md & (busy | start).
- mfhi/mflo in E while busy cannot occur because of the stall; md_rdata always reflects the current registers.

Cancel and flush:
- md_cancel during BUSY does not abort; the accepted operation completes.
- md_cancel in the issue cycle: no start, no register write.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined, these ops are accepted (signed/unsigned as named):
  - 9 madd: {HI,LO} += product.
  - 10 maddu: {HI,LO} += product.
  - 11 msub: {HI,LO} -= product.
  - 12 msubu: {HI,LO} -= product.
- Latency is MULT_CYCLES. The accumulation uses the {HI,LO} value present at completion; 64-bit wrap-around, no overflow flag.
- When undefined, ops 9–12 are treated as none: no start, no stall contribution from E.

Test Plan:
- Reset mid-BUSY: mult 3×4, assert reset at cycle 2 → hi=lo=0, busy=0 immediately, no later write.
- mult 0xFFFFFFFF×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE after exactly 5 busy cycles; multu with the same operands → hi=1, lo=0xFFFFFFFE.
- div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 10; divu 7/0 → hi/lo unchanged, busy for 10 cycles.
- mult in E with d_uses_md=1 → stall high in the start cycle and the 5 busy cycles, low the cycle after; a follow-on mflo returns the product.
- md_cancel with div in E → start=0, busy stays 0; mthi 0x1234 with md_cancel → hi unchanged; without md_cancel → hi=0x1234 next edge.
- MD_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu 1×1 → hi=1, lo=0; macro undefined → op 10 gives no busy, no change.
